// File: rtl/neuron_mac_if.sv
// neuron_mac_if: start/result handshake plus weight-ROM and sample-memory bus of one neuron MAC stage.
interface neuron_mac_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
);
  logic              start;
  logic [DATA_W-1:0] bias;
  logic [DATA_W-1:0] threshold;
  logic              busy;
  logic [15:0]       rom_addr;
  logic [DATA_W-1:0] rom_dout;
  logic [DATA_W-1:0] x_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  sum_out;
  logic              fire;
  modport master (
    output start, bias, threshold, rom_dout, x_data, out_ready,
    input  busy, rom_addr, out_valid, sum_out, fire
  );
  modport slave (
    input  start, bias, threshold, rom_dout, x_data, out_ready,
    output busy, rom_addr, out_valid, sum_out, fire
  );
endinterface

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: walks weight addresses 1..N_INPUTS, accumulates weight*x onto bias, emits sum and step activation.
module neuron_mac_seq #(
  parameter int N_INPUTS = 10,
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 40
) (
  input logic         clk,
  input logic         rst_n,
  neuron_mac_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH, LAST, DONE} state_t;
  state_t              state_q;
  logic                rd_vld_q;
  logic                fire_q;
  logic                out_valid_q;
  logic [15:0]         rom_addr_q;
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    sum_q;
  logic [DATA_W-1:0]   thr_q;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc_d;
  assign prod  = (2*DATA_W)'(bus.rom_dout) * (2*DATA_W)'(bus.x_data);
  assign acc_d = acc_q + ACC_W'(prod);
  // rd_vld_q marks that the memories hold data for an address issued on the previous edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_vld_q    <= 1'b0;
      fire_q      <= 1'b0;
      out_valid_q <= 1'b0;
      rom_addr_q  <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      thr_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          acc_q      <= ACC_W'(bus.bias);
          thr_q      <= bus.threshold;
          rom_addr_q <= 16'd1;
          state_q    <= FETCH;
        end
        FETCH: begin
          rd_vld_q <= 1'b1;
          if (rd_vld_q) acc_q <= acc_d;
          if (rom_addr_q < 16'(N_INPUTS)) rom_addr_q <= rom_addr_q + 16'd1;
          else begin
            rom_addr_q <= '0;
            state_q    <= LAST;
          end
        end
        LAST: begin
          sum_q       <= acc_d;
          fire_q      <= acc_d >= ACC_W'(thr_q);
          out_valid_q <= 1'b1;
          rd_vld_q    <= 1'b0;
          state_q     <= DONE;
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.busy      = state_q != IDLE;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum_out   = sum_q;
  assign bus.fire      = fire_q;
endmodule

// File: tb/tb_neuron_mac_seq.sv
// tb_neuron_mac_seq: directed scoreboard bench for the 10-input build and a 1-input build.
module tb_neuron_mac_seq;
  typedef struct packed {
    logic [39:0] sum;
    logic        fire;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] w [16];
  logic [15:0] xm [16];
  exp_t        sb [$];
  exp_t        e;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc;
  logic [15:0] addr_log [32];
  neuron_mac_if #(.DATA_W(16), .ACC_W(40)) b0 ();
  neuron_mac_if #(.DATA_W(16), .ACC_W(40)) b1 ();
  neuron_mac_seq #(.N_INPUTS(10), .DATA_W(16), .ACC_W(40)) dut (.clk(clk), .rst_n(rst_n), .bus(b0));
  neuron_mac_seq #(.N_INPUTS(1), .DATA_W(16), .ACC_W(40)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    b0.rom_dout <= w[b0.rom_addr[3:0]];
    b0.x_data   <= xm[b0.rom_addr[3:0]];
    b1.rom_dout <= (b1.rom_addr == 16'd1) ? 16'd3 : 16'd0;
    b1.x_data   <= (b1.rom_addr == 16'd1) ? 16'd9 : 16'd0;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic set_vec(input int mode);
    for (int i = 0; i < 16; i++) begin
      w[i]  = 16'd0;
      xm[i] = (mode == 0) ? 16'd1 : (mode == 1) ? 16'(i) : 16'hFFFF;
    end
    if (mode == 2) for (int i = 1; i <= 10; i++) w[i] = 16'hFFFF;
    else begin
      w[3] = 16'd4; w[4] = 16'd5; w[5] = 16'd6; w[6] = 16'd8;
    end
  endtask
  task automatic start_run(input logic [15:0] b, input logic [15:0] t, input logic [39:0] s, input logic f);
    sb.push_back('{sum: s, fire: f});
    b0.bias = b;
    b0.threshold = t;
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    b0.bias = 16'h1234;
    b0.threshold = 16'h4321;
  endtask
  task automatic wait_valid(input int from);
    cyc = from;
    addr_log[cyc] = b0.rom_addr;
    while (!b0.out_valid && cyc < 30) begin
      @(negedge clk);
      cyc++;
      addr_log[cyc] = b0.rom_addr;
    end
  endtask
  task automatic check_result(input string tag);
    chk({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 64'(b0.out_valid), 64'd1);
      chk({tag, "_sum"}, 64'(b0.sum_out), 64'(e.sum));
      chk({tag, "_fire"}, 64'(b0.fire), 64'(e.fire));
    end
  endtask
  task automatic accept(input string tag);
    b0.out_ready = 1'b1;
    @(negedge clk);
    b0.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(b0.out_valid), 64'd0);
    chk({tag, "_busy_drop"}, 64'(b0.busy), 64'd0);
  endtask
  initial begin
    b0.start = 1'b0; b0.out_ready = 1'b0; b0.bias = '0; b0.threshold = '0;
    b1.start = 1'b0; b1.out_ready = 1'b0; b1.bias = '0; b1.threshold = '0;
    set_vec(0);
    repeat (3) @(negedge clk);
    chk("rst_addr", 64'(b0.rom_addr), 64'd0);
    chk("rst_valid", 64'(b0.out_valid), 64'd0);
    chk("rst_busy", 64'(b0.busy), 64'd0);
    chk("rst_sum", 64'(b0.sum_out), 64'd0);
    chk("rst_fire", 64'(b0.fire), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    start_run(16'd0, 16'd0, 40'd23, 1'b1);
    chk("v1_busy", 64'(b0.busy), 64'd1);
    wait_valid(1);
    chk("v1_latency", 64'(cyc - 1), 64'd11);
    for (int k = 1; k <= 10; k++) chk($sformatf("v1_addr%0d", k), 64'(addr_log[k]), 64'(k));
    chk("v1_addr_end", 64'(addr_log[11]), 64'd0);
    check_result("v1");
    accept("v1");
    set_vec(1);
    start_run(16'd7, 16'd117, 40'd117, 1'b1);
    wait_valid(1);
    chk("v2_latency", 64'(cyc - 1), 64'd11);
    check_result("v2");
    accept("v2");
    start_run(16'd7, 16'd118, 40'd117, 1'b0);
    wait_valid(1);
    check_result("v3");
    accept("v3");
    set_vec(2);
    start_run(16'hFFFF, 16'hFFFF, 40'd42948427785, 1'b1);
    wait_valid(1);
    check_result("vmax");
    accept("vmax");
    set_vec(0);
    start_run(16'd0, 16'd0, 40'd23, 1'b1);
    @(negedge clk);
    b0.start = 1'b1; b0.bias = 16'hFFFF; b0.threshold = 16'hFFFF;
    @(negedge clk);
    b0.start = 1'b0;
    wait_valid(3);
    chk("busy_start_latency", 64'(cyc - 1), 64'd11);
    check_result("busy_start");
    for (int i = 0; i < 5; i++) begin
      b0.start = (i == 1);
      chk($sformatf("hold%0d_valid", i), 64'(b0.out_valid), 64'd1);
      chk($sformatf("hold%0d_sum", i), 64'(b0.sum_out), 64'd23);
      chk($sformatf("hold%0d_fire", i), 64'(b0.fire), 64'd1);
      chk($sformatf("hold%0d_busy", i), 64'(b0.busy), 64'd1);
      @(negedge clk);
    end
    b0.start = 1'b0;
    accept("hold");
    @(negedge clk);
    chk("done_start_ignored", 64'(b0.busy), 64'd0);
    start_run(16'd7, 16'd0, 40'd30, 1'b1);
    wait_valid(1);
    check_result("after_hold");
    accept("after_hold");
    start_run(16'd0, 16'd0, 40'd23, 1'b1);
    cyc = 0;
    while (b0.rom_addr != 16'd5 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_addr5", 64'(b0.rom_addr), 64'd5);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_addr", 64'(b0.rom_addr), 64'd0);
    chk("arst_busy", 64'(b0.busy), 64'd0);
    chk("arst_valid", 64'(b0.out_valid), 64'd0);
    chk("arst_sum", 64'(b0.sum_out), 64'd0);
    chk("arst_fire", 64'(b0.fire), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_no_valid", 64'(b0.out_valid), 64'd0);
    start_run(16'd0, 16'd0, 40'd23, 1'b1);
    wait_valid(1);
    check_result("post_rst");
    accept("post_rst");
    b1.bias = 16'd2; b1.threshold = 16'd30; b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    chk("n1_addr1", 64'(b1.rom_addr), 64'd1);
    cyc = 1;
    while (!b1.out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) chk("n1_addr_end", 64'(b1.rom_addr), 64'd0);
    end
    chk("n1_latency", 64'(cyc - 1), 64'd2);
    chk("n1_sum", 64'(b1.sum_out), 64'd29);
    chk("n1_fire", 64'(b1.fire), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/neuron_mac_seq.md
Name: neuron_mac_seq

Overview:
Sequencer and multiply-accumulate stage directly downstream of a per-neuron weight ROM (16-bit address, 16-bit data, registered read, 1-cycle latency, weights at addresses 1..N). On a start request it walks ROM addresses 1..N_INPUTS, multiplies each weight by the matching input sample, and accumulates from a bias value. It then presents the dot-product sum and a step-activation bit to the next layer over a valid/ready handshake.

Parameters:
N_INPUTS, 10, number of weights/inputs per neuron; legal range 1..65535.
DATA_W, 16, width of weights, inputs, bias and threshold (unsigned).
ACC_W, 40, accumulator/sum width; must be >= 2*DATA_W + clog2(N_INPUTS) + 1.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
start  in  1  request a neuron evaluation; accepted only when in IDLE.
bias  in  DATA_W  sampled on the start-accept edge; initial accumulator value.
threshold  in  DATA_W  sampled on the start-accept edge; activation threshold.
busy  out  1  high in any state other than IDLE.
rom_addr  out  16  registered address to the weight ROM and to the input-sample memory.
rom_dout  in  DATA_W  weight returned by the ROM one cycle after rom_addr.
x_data  in  DATA_W  input sample from a 1-cycle-latency memory addressed by rom_addr; aligned with rom_dout.
out_valid  out  1  result valid; held until accepted.
out_ready  in  1  downstream accept.
sum_out  out  ACC_W  bias + sum of weight*x over addresses 1..N_INPUTS (unsigned).
fire  out  1  1 when sum_out >= threshold, zero-extended to ACC_W.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, rom_addr=0, acc=0, sum_out=0, fire=0, out_valid=0, busy=0, and an internal pending-data flag (rd_vld) cleared. Reset mid-evaluation discards all progress; no out_valid is produced.
- States: IDLE, FETCH, LAST, DONE.
- IDLE: rom_addr=0. If start=1 at edge E0: acc<=bias, thr<=threshold, rom_addr<=1, state<=FETCH.
- FETCH: each edge, rd_vld<=1. If rd_vld=1, acc<=acc + rom_dout*x_data (full 2*DATA_W product, zero-extended). If rom_addr<N_INPUTS, rom_addr<=rom_addr+1. Otherwise rom_addr<=0 and state<=LAST. For N_INPUTS=1, the FETCH->LAST transition occurs on the first FETCH edge.
- LAST: consume the final product: sum_out<=acc + rom_dout*x_data, fire<=(that sum >= thr), out_valid<=1, rd_vld<=0, state<=DONE.
- Timing: address k is driven after edge E(k-1), its product is accumulated at edge E(k+1), and out_valid rises at edge E(N_INPUTS+1). Latency is N_INPUTS+1 cycles from start accept to out_valid. The block issues no gaps or stalls in the address sequence.
- DONE: sum_out, fire and out_valid are held stable while out_ready=0. On an edge with out_ready=1: out_valid<=0 and state<=IDLE. start is not accepted in the same cycle and must be presented again in IDLE.
- start while busy: ignored, with no effect on the current evaluation or its sampled bias/threshold.
- No back-pressure exists during FETCH/LAST; out_ready matters only in DONE.
- Arithmetic: all operands are unsigned and there is no saturation. ACC_W sizing guarantees no overflow (the defaults give a worst case of 10*(2^16-1)^2 < 2^40).
- rom_addr never exceeds N_INPUTS and never drives 0 during FETCH.

Test Plan:
- Weights at addr 1..10 = 0,0,4,5,6,8,0,0,0,0; x=1 everywhere; bias=0; threshold=0 -> out_valid rises 11 cycles after start accept; sum_out=23; fire=1; rom_addr sequence 1..10 then 0.
- Same weights; x[i]=i; bias=7; threshold=117 -> sum_out=117, fire=1. Repeat with threshold=118 -> sum_out=117, fire=0.
- All weights and x = 16'hFFFF; bias=16'hFFFF -> sum_out = 10*4294836225 + 65535 = 42948427785, with no overflow.
- Hold out_ready=0 for 5 cycles after out_valid, and pulse start during DONE -> outputs stay stable and start is ignored. Raise out_ready -> out_valid falls next edge, busy falls, and a following start begins a new run.
- Assert rst_n=0 asynchronously while rom_addr=5 -> all outputs are 0 immediately. After release, a new start gives the correct full result (23 for the first vector).
- N_INPUTS=1 build; weight[1]=3, x=9, bias=2 -> sum_out=29 two cycles after start accept.
